serial_rx_align: RTL and testbench

SERIAL_RX_ALIGN -- requirements
Module: serial_rx_align

---
 rtl/serial_rx_align.sv | 235 +++++++++++++++++++++++
 tb/tb_serial_rx_align.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_align.sv
// -----------------------------------------------------------------------------
// serial_rx_align
//
// Bit-serial receiver that recovers byte alignment from a stream of COMMA
// idle characters and then distributes the received bytes round-robin over
// four lanes.
//
// Operation:
//   HUNT    : the last 8 received bits are compared against COMMA on every
//             bit clock. A match fixes the byte boundary.
//   LOCKING : every 8th bit after the match is a word boundary; LOCK_CNT
//             consecutive COMMA words (including the hunt match) declare lock.
//             Any other word drops back to HUNT.
//   ACTIVE  : every word boundary delivers one word to the current lane
//             (0,1,2,3,0,...). Non-COMMA words are latched with valid=1,
//             COMMA words clear that lane's valid. Four consecutive words
//             that are rotated copies of COMMA indicate a bit slip and
//             return the receiver to HUNT, clearing all valids.
//
// Ports:
//   clk_32f            bit clock, one serial bit per rising edge
//   reset_L            asynchronous active-low reset
//   entrada_tx         serial input, MSB of each byte first
//   out0..out3         per-lane received byte (registered)
//   val_out0..val_out3 per-lane valid (registered, level)
//   idle_out           1 while not locked or while the last 4 words were COMMA
//   locked             1 while in ACTIVE
// -----------------------------------------------------------------------------
module serial_rx_align #(
  parameter logic [7:0] COMMA    = 8'hBC,
  parameter int         LOCK_CNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       entrada_tx,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       val_out0,
  output logic       val_out1,
  output logic       val_out2,
  output logic       val_out3,
  output logic       idle_out,
  output logic       locked
);

  localparam logic [3:0] LOCK_TARGET = LOCK_CNT[3:0];
  // Number of rotated-COMMA words already seen when the next one drops lock.
  localparam logic [2:0] MIS_LAST    = 3'd3;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LOCKING,
    ST_ACTIVE
  } state_t;

  state_t      state_reg;
  // Only the 7 older bits of the byte window need storing: the full 8-bit
  // window seen on a given edge is these bits plus the incoming bit.
  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt_reg;
  logic [3:0]  comma_cnt_reg;
  logic [1:0]  lane_cnt_reg;
  logic [2:0]  mis_cnt_reg;
  // COMMA flags of the three most recent ACTIVE words; with the current
  // word this gives the "one round of pure COMMA" idle condition.
  logic [2:0]  comma_hist_reg;
  logic        idle_reg;
  logic        locked_reg;

  logic [7:0]  word_next;
  logic        word_is_comma;
  logic [7:1]  rot_hit;
  logic        word_is_rot;
  logic        boundary;
  logic        lane_we;
  logic        lose_lock;

  // The word completed on this edge: older bits plus the bit being sampled,
  // so lane outputs update on the edge that samples the word's last bit.
  assign word_next     = {shift_reg, entrada_tx};
  assign word_is_comma = (word_next == COMMA);

  // One comparator per nonzero left rotation of COMMA.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi = gi + 1) begin : g_rot
      localparam logic [7:0] ROT = {COMMA[7-gi:0], COMMA[7:8-gi]};
      assign rot_hit[gi] = (word_next == ROT);
    end
  endgenerate

  // A rotation that happens to equal COMMA itself is treated as COMMA.
  assign word_is_rot = (|rot_hit) && !word_is_comma;

  // Counter reached 7: the incoming bit is the 8th since the last boundary.
  assign boundary  = (bit_cnt_reg == 3'd7);
  assign lane_we   = (state_reg == ST_ACTIVE) && boundary;
  assign lose_lock = lane_we && word_is_rot && (mis_cnt_reg == MIS_LAST);

  // ---------------------------------------------------------------------------
  // Alignment state machine and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_reg      <= ST_HUNT;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      comma_cnt_reg  <= '0;
      lane_cnt_reg   <= '0;
      mis_cnt_reg    <= '0;
      comma_hist_reg <= '0;
      idle_reg       <= 1'b1;
      locked_reg     <= 1'b0;
    end else begin
      shift_reg <= word_next[6:0];

      case (state_reg)
        ST_HUNT: begin
          if (word_is_comma) begin
            bit_cnt_reg   <= '0;
            comma_cnt_reg <= 4'd1;
            if (LOCK_TARGET == 4'd1) begin
              // A single COMMA is enough: lock on the hunt match itself.
              state_reg      <= ST_ACTIVE;
              locked_reg     <= 1'b1;
              lane_cnt_reg   <= '0;
              mis_cnt_reg    <= '0;
              comma_hist_reg <= 3'b111;
              idle_reg       <= 1'b1;
            end else begin
              state_reg <= ST_LOCKING;
            end
          end
        end

        ST_LOCKING: begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (boundary) begin
            if (word_is_comma) begin
              comma_cnt_reg <= comma_cnt_reg + 4'd1;
              if (comma_cnt_reg + 4'd1 == LOCK_TARGET) begin
                // The locking COMMA is not delivered to any lane; the
                // first word after it belongs to lane 0.
                state_reg      <= ST_ACTIVE;
                locked_reg     <= 1'b1;
                lane_cnt_reg   <= '0;
                mis_cnt_reg    <= '0;
                comma_hist_reg <= 3'b111;
                idle_reg       <= 1'b1;
              end
            end else begin
              state_reg     <= ST_HUNT;
              comma_cnt_reg <= '0;
            end
          end
        end

        ST_ACTIVE: begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          if (boundary) begin
            if (lose_lock) begin
              state_reg      <= ST_HUNT;
              locked_reg     <= 1'b0;
              idle_reg       <= 1'b1;
              bit_cnt_reg    <= '0;
              comma_cnt_reg  <= '0;
              lane_cnt_reg   <= '0;
              mis_cnt_reg    <= '0;
              comma_hist_reg <= '0;
            end else begin
              lane_cnt_reg   <= lane_cnt_reg + 2'd1;
              comma_hist_reg <= {comma_hist_reg[1:0], word_is_comma};
              idle_reg       <= &{comma_hist_reg, word_is_comma};
              if (word_is_rot) begin
                mis_cnt_reg <= mis_cnt_reg + 3'd1;
              end else begin
                mis_cnt_reg <= '0;
              end
            end
          end
        end

        default: begin
          state_reg  <= ST_HUNT;
          locked_reg <= 1'b0;
          idle_reg   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane output registers
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
      logic [7:0] lane_out_reg;
      logic       lane_val_reg;
      logic       lane_sel;

      assign lane_sel = lane_we && (lane_cnt_reg == 2'(gi));

      always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
          lane_out_reg <= '0;
          lane_val_reg <= 1'b0;
        end else if (lose_lock) begin
          // Slip detected: every lane goes invalid, data is left as it was.
          lane_val_reg <= 1'b0;
        end else if (lane_sel) begin
          if (word_is_comma) begin
            lane_val_reg <= 1'b0;
          end else begin
            lane_out_reg <= word_next;
            lane_val_reg <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign out0     = g_lane[0].lane_out_reg;
  assign out1     = g_lane[1].lane_out_reg;
  assign out2     = g_lane[2].lane_out_reg;
  assign out3     = g_lane[3].lane_out_reg;
  assign val_out0 = g_lane[0].lane_val_reg;
  assign val_out1 = g_lane[1].lane_val_reg;
  assign val_out2 = g_lane[2].lane_val_reg;
  assign val_out3 = g_lane[3].lane_val_reg;
  assign idle_out = idle_reg;
  assign locked   = locked_reg;

endmodule

// File: tb/tb_serial_rx_align.sv
// -----------------------------------------------------------------------------
// tb_serial_rx_align
//
// Drives one serial bit stream into two receivers (LOCK_CNT=4 and LOCK_CNT=1)
// and compares them with a bit-stream reference model held in the bench. The
// model keeps the whole received bit history since reset and derives word
// boundaries, lanes and lock state from bit positions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_rx_align;

  localparam logic [7:0] COMMA  = 8'hBC;
  localparam int         LOCK_A = 4;
  localparam int         LOCK_B = 1;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b1;
  logic       entrada_tx = 1'b0;
  logic [7:0] out_a [4];
  logic       val_a [4];
  logic       idle_a, locked_a;
  logic [7:0] out_b [4];
  logic       val_b [4];
  logic       idle_b, locked_b;

  always #5 clk_32f = ~clk_32f;

  serial_rx_align #(.COMMA(COMMA), .LOCK_CNT(LOCK_A)) dut_a (
    .clk_32f(clk_32f), .reset_L(reset_L), .entrada_tx(entrada_tx),
    .out0(out_a[0]), .out1(out_a[1]), .out2(out_a[2]), .out3(out_a[3]),
    .val_out0(val_a[0]), .val_out1(val_a[1]), .val_out2(val_a[2]), .val_out3(val_a[3]),
    .idle_out(idle_a), .locked(locked_a)
  );

  serial_rx_align #(.COMMA(COMMA), .LOCK_CNT(LOCK_B)) dut_b (
    .clk_32f(clk_32f), .reset_L(reset_L), .entrada_tx(entrada_tx),
    .out0(out_b[0]), .out1(out_b[1]), .out2(out_b[2]), .out3(out_b[3]),
    .val_out0(val_b[0]), .val_out1(val_b[1]), .val_out2(val_b[2]), .val_out3(val_b[3]),
    .idle_out(idle_b), .locked(locked_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------------------------------------------------------------------
  // Reference model (index 0 -> dut_a, index 1 -> dut_b)
  // mode: 0 hunting, 1 counting commas, 2 locked
  // ---------------------------------------------------------------------------
  bit         bits_q[$];
  int         m_lock [2] = '{LOCK_A, LOCK_B};
  int         m_mode [2];
  int         m_anchor [2];   // bit count at which the alignment was fixed
  int         m_cnt [2];
  int         m_rot [2];
  int         m_run [2];      // consecutive COMMA words seen while locked
  logic [7:0] m_out [2][4];
  logic       m_val [2][4];
  logic       m_idle [2];
  logic       m_locked [2];

  localparam logic [37:0] RESET_VEC = {32'h0, 4'b0000, 1'b1, 1'b0};

  function automatic bit is_rot_comma(logic [7:0] w);
    logic [15:0] dbl;
    dbl = {COMMA, COMMA};
    for (int k = 1; k < 8; k++) begin
      if (w == dbl[15-k -: 8] && w != COMMA) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    bits_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_anchor[i] = 0; m_cnt[i] = 0; m_rot[i] = 0; m_run[i] = 0;
      for (int l = 0; l < 4; l++) begin
        m_out[i][l] = 8'h00;
        m_val[i][l] = 1'b0;
      end
      m_idle[i] = 1'b1;
      m_locked[i] = 1'b0;
    end
  endfunction

  function automatic void model_go_active(int i, int n);
    m_mode[i] = 2; m_anchor[i] = n; m_locked[i] = 1'b1;
    m_run[i] = 4; m_idle[i] = 1'b1; m_rot[i] = 0;
  endfunction

  function automatic void model_step(bit b);
    int         n;
    int         lane;
    logic [7:0] w;
    bit         isc;
    bits_q.push_back(b);
    n = bits_q.size();
    for (int j = 0; j < 8; j++) w[j] = (n - 1 - j >= 0) ? bits_q[n-1-j] : 1'b0;
    isc = (w == COMMA);
    for (int i = 0; i < 2; i++) begin
      if (m_mode[i] == 0) begin
        if (isc) begin
          m_anchor[i] = n; m_cnt[i] = 1;
          if (m_lock[i] == 1) model_go_active(i, n);
          else m_mode[i] = 1;
        end
      end else if ((n - m_anchor[i]) % 8 == 0) begin
        if (m_mode[i] == 1) begin
          if (isc) begin
            m_cnt[i]++;
            if (m_cnt[i] == m_lock[i]) model_go_active(i, n);
          end else begin
            m_mode[i] = 0; m_cnt[i] = 0;
          end
        end else begin
          lane = ((n - m_anchor[i]) / 8 - 1) % 4;
          if (isc) begin
            m_val[i][lane] = 1'b0; m_rot[i] = 0; m_run[i]++;
            m_idle[i] = (m_run[i] >= 4);
          end else begin
            m_run[i] = 0;
            m_rot[i] = is_rot_comma(w) ? m_rot[i] + 1 : 0;
            if (m_rot[i] == 4) begin
              m_mode[i] = 0; m_cnt[i] = 0; m_rot[i] = 0;
              m_locked[i] = 1'b0; m_idle[i] = 1'b1;
              for (int l = 0; l < 4; l++) m_val[i][l] = 1'b0;
            end else begin
              m_out[i][lane] = w; m_val[i][lane] = 1'b1; m_idle[i] = 1'b0;
            end
          end
        end
      end
    end
  endfunction

  function automatic logic [37:0] model_vec(int i);
    return {m_out[i][0], m_out[i][1], m_out[i][2], m_out[i][3],
            m_val[i][0], m_val[i][1], m_val[i][2], m_val[i][3], m_idle[i], m_locked[i]};
  endfunction

  function automatic logic [37:0] dut_vec(int i);
    if (i == 0)
      return {out_a[0], out_a[1], out_a[2], out_a[3],
              val_a[0], val_a[1], val_a[2], val_a[3], idle_a, locked_a};
    return {out_b[0], out_b[1], out_b[2], out_b[3],
            val_b[0], val_b[1], val_b[2], val_b[3], idle_b, locked_b};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus primitives
  // ---------------------------------------------------------------------------
  task automatic send_bit(input bit b);
    @(negedge clk_32f);
    entrada_tx = b;
    @(posedge clk_32f);
    #1;
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    $display("[TB] byte 0x%02h  locked_a=%0b locked_b=%0b", v, locked_a, locked_b);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    entrada_tx = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL reset_state inst%0d got=%h exp=%h", k, dut_vec(k), RESET_VEC);
      end
    end
    send_bit(1'b1);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL first_edge inst%0d got=%h exp=%h", k, dut_vec(k), RESET_VEC);
      end
    end
  endtask

  task automatic test_basic_lock();
    logic [7:0] data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    for (int c = 0; c < 4; c++) begin
      send_byte(COMMA);
      n_tests++;
      if (locked_a !== (c == 3)) begin
        n_fail++;
        $display("FAIL lock_timing comma%0d got=%0b exp=%0b", c, locked_a, (c == 3));
      end
    end
    for (int d = 0; d < 4; d++) begin
      send_byte(data[d]);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL basic_lock inst%0d got=%h exp=%h", k, dut_vec(k), model_vec(k));
        end
      end
    end
    n_tests++;
    if (dut_vec(0) !== {8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL basic_lanes got=%h exp=%h", dut_vec(0),
               {8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 1'b0, 1'b1});
    end
  endtask

  task automatic test_mixed();
    logic [7:0] data [4] = '{8'h55, COMMA, 8'h66, COMMA};
    for (int d = 0; d < 4; d++) begin
      send_byte(data[d]);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL mixed inst%0d got=%h exp=%h", k, dut_vec(k), model_vec(k));
        end
      end
    end
    n_tests++;
    if (dut_vec(0) !== {8'h55, 8'h22, 8'h66, 8'h44, 4'b1010, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mixed_lanes got=%h exp=%h", dut_vec(0),
               {8'h55, 8'h22, 8'h66, 8'h44, 4'b1010, 1'b0, 1'b1});
    end
  endtask

  task automatic test_slip();
    send_bit(1'b0);
    for (int c = 0; c < 4; c++) begin
      send_byte(COMMA);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL slip inst%0d got=%h exp=%h", k, dut_vec(k), model_vec(k));
        end
      end
    end
    n_tests++;
    if ({val_a[0], val_a[1], val_a[2], val_a[3], idle_a, locked_a} !== 6'b000010) begin
      n_fail++;
      $display("FAIL slip_unlock got=%b exp=000010",
               {val_a[0], val_a[1], val_a[2], val_a[3], idle_a, locked_a});
    end
    repeat (3) send_byte(COMMA);
    n_tests++;
    if (locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL slip_relock got=%0b exp=1", locked_a);
    end
  endtask

  task automatic test_lock_abort();
    do_reset();
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h00);
    n_tests++;
    if ({val_a[0], val_a[1], val_a[2], val_a[3], idle_a, locked_a} !== 6'b000010) begin
      n_fail++;
      $display("FAIL abort_state got=%b exp=000010",
               {val_a[0], val_a[1], val_a[2], val_a[3], idle_a, locked_a});
    end
    for (int c = 0; c < 4; c++) begin
      send_byte(COMMA);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL abort_relock inst%0d got=%h exp=%h", k, dut_vec(k), model_vec(k));
        end
      end
    end
  endtask

  task automatic test_offset();
    logic [7:0] data [4];
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    repeat (4) send_byte(COMMA);
    n_tests++;
    if (locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL offset_lock got=%0b exp=1", locked_a);
    end
    for (int d = 0; d < 4; d++) begin
      do data[d] = 8'($urandom_range(0, 255));
      while (data[d] == COMMA || is_rot_comma(data[d]));
      send_byte(data[d]);
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL offset inst%0d got=%h exp=%h", k, dut_vec(k), model_vec(k));
        end
      end
    end
    n_tests++;
    if (dut_vec(0) !== {data[0], data[1], data[2], data[3], 4'b1111, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL offset_lanes got=%h exp=%h", dut_vec(0),
               {data[0], data[1], data[2], data[3], 4'b1111, 1'b0, 1'b1});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v = 8'h99;
    for (int i = 7; i >= 5; i--) send_bit(v[i]);
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL async_reset inst%0d got=%h exp=%h", k, dut_vec(k), RESET_VEC);
      end
    end
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    repeat (4) send_byte(v);
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (dut_vec(k) !== RESET_VEC) begin
        n_fail++;
        $display("FAIL no_valid_before_lock inst%0d got=%h exp=%h", k, dut_vec(k), RESET_VEC);
      end
    end
    repeat (4) send_byte(COMMA);
    n_tests++;
    if (locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_relock got=%0b exp=1", locked_a);
    end
  endtask

  task automatic test_random();
    int r;
    int nb;
    do_reset();
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        send_byte(COMMA);
      end else if (r == 4) begin
        nb = $urandom_range(1, 7);
        for (int i = 0; i < nb; i++) send_bit(1'($urandom_range(0, 1)));
        $display("[TB] slip %0d bits", nb);
      end else begin
        send_byte(8'($urandom_range(0, 255)));
      end
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dut_vec(k) !== model_vec(k)) begin
          n_fail++;
          $display("FAIL random item%0d inst%0d got=%h exp=%h", t, k, dut_vec(k), model_vec(k));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_lock();
    test_mixed();
    test_slip();
    test_lock_abort();
    test_offset();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
